// File: rtl/draw_num_grid_if.sv
// vga_if: VGA timing and colour bundle passed between redraw stages.
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
    modport out (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_num_grid.sv
// draw_num_grid: overlays a coloured digit glyph for each board field, centred in its
// button cell, onto the VGA stream. Cell coordinates come from incremental counters so
// the stream sees a fixed three-cycle latency.
module draw_num_grid #(
    parameter int GRID_MAX = 16,
    parameter int GLYPH_W  = 8,
    parameter int GLYPH_H  = 16,
    parameter int LAT      = 3,
    localparam int CW      = $clog2(GRID_MAX),
    localparam int GRW     = $clog2(GLYPH_H),
    localparam int GXW     = $clog2(GLYPH_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [10:0]        board_xpos,
    input  logic [10:0]        board_ypos,
    input  logic [6:0]         button_size,
    input  logic [4:0]         button_num,
    output logic [CW-1:0]      cell_x,
    output logic [CW-1:0]      cell_y,
    input  logic [3:0]         cell_val,
    output logic [3:0]         glyph_code,
    output logic [GRW-1:0]     glyph_row,
    input  logic [GLYPH_W-1:0] glyph_bits,
    vga_if.in                  in,
    vga_if.out                 out
);
    // Packed stream word: {vcount, hcount, vsync, vblnk, hsync, hblnk, rgb}.
    localparam int VW = 38;
    localparam logic [6:0]     GW7    = 7'(GLYPH_W);
    localparam logic [6:0]     GH7    = 7'(GLYPH_H);
    localparam logic [GXW-1:0] GX_MAX = GXW'(GLYPH_W - 1);

    logic frame_start;
    assign frame_start = (in.vcount == 11'd0) && (in.hcount == 11'd0);

    logic        en_q;
    logic [6:0]  bs_q, offx_q, offy_q;
    logic [4:0]  num_q;
    logic [10:0] xpos_q, ypos_q;

    // Latch the board geometry and enable once per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= 1'b0;
            bs_q   <= '0;
            num_q  <= '0;
            xpos_q <= '0;
            ypos_q <= '0;
            offx_q <= '0;
            offy_q <= '0;
        end else if (frame_start) begin
            en_q   <= en;
            bs_q   <= button_size;
            num_q  <= button_num;
            xpos_q <= board_xpos;
            ypos_q <= board_ypos;
            offx_q <= (button_size - GW7) >> 1;
            offy_q <= (button_size - GH7) >> 1;
        end
    end

    // The frame-start pixel itself must already see the new geometry.
    logic [6:0]  bs_use;
    logic [4:0]  num_use;
    logic [10:0] xpos_use, ypos_use;
    logic        board_ok;
    assign bs_use   = frame_start ? button_size : bs_q;
    assign num_use  = frame_start ? button_num  : num_q;
    assign xpos_use = frame_start ? board_xpos  : xpos_q;
    assign ypos_use = frame_start ? board_ypos  : ypos_q;
    assign board_ok = (bs_use != 7'd0) && (num_use != 5'd0);

    logic [6:0]  px_q, px_d, py_q, py_d;
    logic [CW:0] col_q, col_d, row_q, row_d;
    logic        in_x_q, in_x_d, in_y_q, in_y_d;

    // Stage 0 next state: pixel-in-cell and cell index counters with board window flags.
    always_comb begin
        px_d   = px_q;
        col_d  = col_q;
        in_x_d = in_x_q;
        py_d   = py_q;
        row_d  = row_q;
        in_y_d = in_y_q;
        if (in.hcount == xpos_use) begin
            px_d   = '0;
            col_d  = '0;
            in_x_d = board_ok;
        end else if (in.hcount == 11'd0) begin
            in_x_d = 1'b0;
        end else if (in_x_q) begin
            if (px_q == bs_use - 7'd1) begin
                px_d  = '0;
                col_d = col_q + 1'b1;
                if (int'(col_d) == int'(num_use)) in_x_d = 1'b0;
            end else begin
                px_d = px_q + 7'd1;
            end
        end
        if (in.hcount == 11'd0) begin
            if (in.vcount == ypos_use) begin
                py_d   = '0;
                row_d  = '0;
                in_y_d = board_ok;
            end else if (in.vcount == 11'd0) begin
                in_y_d = 1'b0;
            end else if (in_y_q) begin
                if (py_q == bs_use - 7'd1) begin
                    py_d  = '0;
                    row_d = row_q + 1'b1;
                    if (int'(row_d) == int'(num_use)) in_y_d = 1'b0;
                end else begin
                    py_d = py_q + 7'd1;
                end
            end
        end
    end

    // Stage 0 registers; the memory address only moves while inside the board.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_q   <= '0;
            py_q   <= '0;
            col_q  <= '0;
            row_q  <= '0;
            in_x_q <= 1'b0;
            in_y_q <= 1'b0;
            cell_x <= '0;
            cell_y <= '0;
        end else begin
            px_q   <= px_d;
            py_q   <= py_d;
            col_q  <= col_d;
            row_q  <= row_d;
            in_x_q <= in_x_d;
            in_y_q <= in_y_d;
            if (in_x_d && in_y_d) begin
                cell_x <= col_d[CW-1:0];
                cell_y <= row_d[CW-1:0];
            end
        end
    end

    logic [6:0] gx, gy;
    logic       hit;

    // Stage 1 glyph-local coordinates; underflow wraps large and reads as a miss.
    always_comb begin
        gx  = px_q - offx_q;
        gy  = py_q - offy_q;
        hit = in_x_q && in_y_q && (gx < GW7) && (gy < GH7);
    end

    logic [GXW-1:0] gx_q;
    logic           hit_q;

    // Stage 1 registers: glyph ROM address and the hit/column for stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gx_q       <= '0;
            hit_q      <= 1'b0;
            glyph_row  <= '0;
            glyph_code <= '0;
        end else begin
            gx_q       <= gx[GXW-1:0];
            hit_q      <= hit;
            glyph_row  <= gy[GRW-1:0];
            glyph_code <= cell_val;
        end
    end

    logic [VW-1:0] dly_q [LAT-1];
    logic [VW-1:0] tail;
    assign tail = dly_q[LAT-2];

    // Stream delay line; the output register below supplies the final stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT - 1; i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= {in.vcount, in.hcount, in.vsync, in.vblnk, in.hsync, in.hblnk, in.rgb};
            for (int i = 1; i < LAT - 1; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    logic        pix, draw;
    logic [11:0] pal_rgb;

    // Stage 2 draw decision and per-digit palette; blanked pixels are never touched.
    always_comb begin
        pix  = glyph_bits[GX_MAX - gx_q];
        draw = en_q && hit_q && pix && (glyph_code >= 4'd1) && (glyph_code <= 4'd8) &&
               !tail[14] && !tail[12];
        case (glyph_code)
            4'd1:    pal_rgb = 12'h00F;
            4'd2:    pal_rgb = 12'h080;
            4'd3:    pal_rgb = 12'hF00;
            4'd4:    pal_rgb = 12'h008;
            4'd5:    pal_rgb = 12'h800;
            4'd6:    pal_rgb = 12'h088;
            4'd7:    pal_rgb = 12'h000;
            4'd8:    pal_rgb = 12'h888;
            default: pal_rgb = 12'h000;
        endcase
    end

    logic [VW-1:0] out_q;

    // Output register: timing fields pass through, rgb replaced where a glyph pixel is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= '0;
        else     out_q <= {tail[VW-1:12], draw ? pal_rgb : tail[11:0]};
    end

    assign {out.vcount, out.hcount, out.vsync, out.vblnk, out.hsync, out.hblnk, out.rgb} = out_q;
endmodule

// File: tb/tb_draw_num_grid.sv
// tb_draw_num_grid: directed frames with a reference pixel model and an output scoreboard.
module tb_draw_num_grid;
    localparam int GW = 8;
    localparam int GH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [10:0] board_xpos, board_ypos;
    logic [6:0]  button_size;
    logic [4:0]  button_num;
    logic [3:0]  cell_x, cell_y, cell_val, glyph_code, glyph_row;
    logic [7:0]  glyph_bits;

    logic [3:0] mem [16][16];
    logic [7:0] rom [16][16];

    vga_if vin();
    vga_if vout();

    always #5 clk = ~clk;

    // Board memory and glyph ROM answer the registered address combinationally.
    assign cell_val   = mem[cell_y][cell_x];
    assign glyph_bits = rom[glyph_code][glyph_row];

    draw_num_grid dut (
        .clk(clk), .rst(rst), .en(en),
        .board_xpos(board_xpos), .board_ypos(board_ypos),
        .button_size(button_size), .button_num(button_num),
        .cell_x(cell_x), .cell_y(cell_y), .cell_val(cell_val),
        .glyph_code(glyph_code), .glyph_row(glyph_row), .glyph_bits(glyph_bits),
        .in(vin), .out(vout)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [37:0] sbq [$];
    bit          chkq [$];
    bit          spec_on = 0;

    bit          m_en = 0, m_addr_ok = 0;
    int          m_bs = 0, m_num = 0, m_x = 0, m_y = 0;
    logic [3:0]  exp_cx = '0, exp_cy = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pal(input int d);
        case (d)
            1: return 12'h00F;
            2: return 12'h080;
            3: return 12'hF00;
            4: return 12'h008;
            5: return 12'h800;
            6: return 12'h088;
            7: return 12'h000;
            8: return 12'h888;
            default: return 12'h000;
        endcase
    endfunction

    function automatic bit locate(input int h, input int v,
                                  output int c, output int r, output int px, output int py);
        c = 0; r = 0; px = 0; py = 0;
        if (m_bs == 0 || m_num == 0) return 0;
        if (h < m_x || h >= m_x + m_num * m_bs || v < m_y || v >= m_y + m_num * m_bs) return 0;
        c  = (h - m_x) / m_bs;
        r  = (v - m_y) / m_bs;
        px = (h - m_x) % m_bs;
        py = (v - m_y) % m_bs;
        return 1;
    endfunction

    // One pixel: check what has emerged, then drive the next pixel and queue its expectation.
    task automatic step(input int h, input int v, input bit hb, input bit vb);
        logic [37:0] e;
        logic [11:0] rgbin, rgbexp;
        logic [7:0]  rowbits;
        bit          s, w, hs, vs;
        int          c, r, px, py, offx, offy, gx, gy, val;
        @(negedge clk);
        if (sbq.size() == 3) begin
            e = sbq.pop_front();
            s = chkq.pop_front();
            check("vga_out", {vout.vcount, vout.hcount, vout.vsync, vout.vblnk,
                              vout.hsync, vout.hblnk, vout.rgb}, e);
            if (s) check("rgb_800", vout.rgb, 12'h800);
        end
        check("cell_addr", {cell_y, cell_x}, {exp_cy, exp_cx});
        if (v == 0 && h == 0) begin
            m_en = en; m_bs = button_size; m_num = button_num;
            m_x = board_xpos; m_y = board_ypos; m_addr_ok = 1;
        end
        rgbin = 12'($urandom);
        hs = (h < 2);
        vs = (v == 0);
        vin.vcount = 11'(v); vin.hcount = 11'(h);
        vin.hsync = hs; vin.vsync = vs; vin.hblnk = hb; vin.vblnk = vb; vin.rgb = rgbin;
        rgbexp = rgbin;
        w = locate(h, v, c, r, px, py);
        if (w && m_addr_ok) begin
            exp_cx = 4'(c);
            exp_cy = 4'(r);
        end
        if (w && m_en && !hb && !vb) begin
            offx = ((m_bs - GW) & 127) >> 1;
            offy = ((m_bs - GH) & 127) >> 1;
            gx   = (px - offx) & 127;
            gy   = (py - offy) & 127;
            val  = int'(mem[r][c]);
            if (gx < GW && gy < GH && val >= 1 && val <= 8) begin
                rowbits = rom[val][gy];
                if (rowbits[GW-1-gx]) rgbexp = pal(val);
            end
        end
        sbq.push_back({11'(v), 11'(h), vs, vb, hs, hb, rgbexp});
        chkq.push_back(spec_on && v == 204 && h >= 176 && h <= 183);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_out", {vout.vcount, vout.hcount, vout.vsync, vout.vblnk,
                          vout.hsync, vout.hblnk, vout.rgb}, 64'd0);
        check("rst_addr", {cell_y, cell_x, glyph_code, glyph_row}, 64'd0);
        #1 rst = 1'b0;
        sbq.delete();
        chkq.delete();
        exp_cx = '0; exp_cy = '0;
        m_en = 0; m_addr_ok = 0;
    endtask

    // Lines inside [vlo,vhi] are full width; the rest only carry the hcount==0 step.
    task automatic run_frame(input int hfull, input int vtot, input int vlo, input int vhi,
                             input int tog_v, input int rst_v);
        int hl;
        for (int v = 0; v < vtot; v++) begin
            hl = (v >= vlo && v <= vhi) ? hfull : 4;
            for (int h = 0; h < hl; h++) begin
                if (v == tog_v && h == 0) begin
                    en = 1'b1;
                    board_xpos = board_xpos + 11'd3;
                    button_size = button_size + 7'd1;
                end
                step(h, v, (hl == hfull) && (h >= hfull - 8), v >= vtot - 2);
                if (v == rst_v && h == 200) reset_pulse();
            end
        end
    endtask

    task automatic fill_mem(input int mode);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                case (mode)
                    1:       mem[r][c] = 4'd0;
                    2:       mem[r][c] = 4'($urandom_range(15, 9));
                    default: mem[r][c] = 4'($urandom_range(15, 0));
                endcase
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0; board_xpos = '0; board_ypos = '0; button_size = '0; button_num = '0;
        vin.vcount = 11'd5; vin.hcount = '0; vin.vsync = 0; vin.vblnk = 0;
        vin.hsync = 0; vin.hblnk = 0; vin.rgb = '0;
        for (int k = 0; k < 16; k++)
            for (int r = 0; r < 16; r++) rom[k][r] = 8'($urandom);
        rom[5][0] = 8'hFF;
        fill_mem(1);
        repeat (3) @(negedge clk);
        check("por_out", {vout.vcount, vout.hcount, vout.vsync, vout.vblnk,
                          vout.hsync, vout.hblnk, vout.rgb}, 64'd0);
        check("por_addr", {cell_y, cell_x, glyph_code, glyph_row}, 64'd0);
        rst = 1'b0;

        // 10x10 board at (100,100), pitch 32, digit 5 in cell (2,3).
        en = 1'b1; board_xpos = 11'd100; board_ypos = 11'd100;
        button_size = 7'd32; button_num = 5'd10;
        fill_mem(0);
        mem[3][2] = 4'd5;
        spec_on = 1;
        run_frame(432, 212, 196, 211, -1, -1);
        spec_on = 0;

        // Empty fields, then no-glyph values: pure pass-through.
        fill_mem(1);
        run_frame(432, 112, 100, 111, -1, -1);
        fill_mem(2);
        run_frame(432, 112, 100, 111, -1, -1);

        // en low at frame start, raised mid-frame with geometry changes.
        fill_mem(0);
        en = 1'b0;
        run_frame(432, 112, 100, 111, 105, -1);
        run_frame(432, 112, 100, 111, -1, -1);

        // 16x16 board of pitch 8: address sweeps the full grid.
        en = 1'b1; board_xpos = 11'd4; board_ypos = 11'd2;
        button_size = 7'd8; button_num = 5'd16;
        run_frame(136, 40, 0, 39, -1, -1);

        // Mid-line reset, then recovery on the following frame.
        board_xpos = 11'd100; board_ypos = 11'd100;
        button_size = 7'd32; button_num = 5'd10;
        fill_mem(0);
        run_frame(432, 112, 100, 111, -1, 105);
        run_frame(432, 112, 100, 111, -1, -1);

        // Zero fields per side disables the overlay.
        button_num = 5'd0;
        run_frame(432, 110, 100, 109, -1, -1);

        for (int h = 0; h < 4; h++) step(h, 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/draw_num_grid.md
Name: draw_num_grid

Overview:
- Parametrised successor of the per-field mine-count overlay in the redraw path.
- Overlays a glyph for each board field's value onto the VGA stream, centred inside each button cell.
- Board size, cell size and glyph size are run-time or parameter configurable; each digit has its own colour.
- Cell coordinates come from incremental counters, not division, so the block sits in the pipeline with a fixed latency.

Parameters:
GRID_MAX, 16, maximum fields per board side; sets cell index width CW = clog2(GRID_MAX).
GLYPH_W, 8, glyph width in pixels.
GLYPH_H, 16, glyph height in pixels.
LAT, 3, fixed pipeline latency of the vga_if stream through the block; only 3 is legal.

Ports:
clk  in  1  pixel clock.
rst  in  1  asynchronous, active-high reset.
en  in  1  overlay enable; sampled on the first cycle of each frame (vcount==0 && hcount==0).
board_xpos  in  11  board left edge, in pixels.
board_ypos  in  11  board top edge, in pixels.
button_size  in  7  cell pitch in pixels; must be >= GLYPH_W and >= GLYPH_H.
button_num  in  5  fields per side, 1..GRID_MAX.
cell_x  out  CW  column address to the board-value memory.
cell_y  out  CW  row address to the board-value memory.
cell_val  in  4  value of the addressed field; valid one cycle after the address. 0 = empty, 1..8 = count, 9..15 = no glyph.
glyph_code  out  4  glyph ROM character select; equals the registered cell_val.
glyph_row  out  clog2(GLYPH_H)  glyph ROM row select.
glyph_bits  in  GLYPH_W  glyph ROM row data; valid one cycle after the address; MSB is the leftmost pixel.
in  vga_if.in  -  incoming timing and rgb: vcount 11, hcount 11, vsync, vblnk, hsync, hblnk, rgb 12.
out  vga_if.out  -  same fields, delayed by LAT cycles.

Behaviour:
- Reset (async, rst=1): all out fields = 0; cell_x = cell_y = 0; glyph_code = glyph_row = 0; all counters and pipeline registers = 0; en latch = 0.
- Frame latch: on vcount==0 && hcount==0, register en, button_size, button_num, board_xpos and board_ypos. Compute the offsets once and register them:
  - offx = (button_size - GLYPH_W) >> 1
  - offy = (button_size - GLYPH_H) >> 1
  - Mid-frame input changes have no effect until the next frame.
- Horizontal counters (stage 0):
  - At hcount == board_xpos: col = 0, px = 0.
  - Each following pixel: px++. When px == button_size - 1, px wraps to 0 and col++.
  - in_x = 1 while board_xpos <= hcount < board_xpos + button_num*button_size.
- Vertical counters (stage 0):
  - Advance only on the hcount==0 cycle of each line.
  - At vcount == board_ypos: row = 0, py = 0. Then py and row wrap and increment the same way as px and col.
  - in_y uses the same window rule as in_x.
- Cell addressing: cell_x = col and cell_y = row, registered at the end of stage 0. When out of the board, they hold their last value.
- Stage 1:
  - Register cell_val.
  - gx = px - offx, gy = py - offy.
  - glyph_hit = in_x && in_y && gx < GLYPH_W && gy < GLYPH_H (unsigned compare, so underflow is a miss).
  - glyph_row = gy; glyph_code = cell_val.
- Stage 2:
  - pix = glyph_bits[GLYPH_W-1-gx_d].
  - Draw when all hold: en latch = 1, glyph_hit_d = 1, cell_val_d in 1..8, pix = 1.
  - Palette: 1=12'h00F, 2=12'h080, 3=12'hF00, 4=12'h008, 5=12'h800, 6=12'h088, 7=12'h000, 8=12'h888.
- Output: rgb = palette colour when drawn, otherwise the input rgb delayed by LAT. All sync, blank and count fields are delayed by exactly LAT, so alignment is cycle-exact.
- Boundaries:
  - Last column/row: col or row reaching button_num ends the window; no addresses beyond button_num-1 are issued.
  - button_size == GLYPH_W: offx = 0.
  - Pixels under hblnk/vblnk pass through unmodified.
  - button_num = 0 or button_size = 0 disables drawing for that frame.
- Reset mid-frame: outputs go to 0 immediately. Drawing resumes only after the next frame latch, so no partial-frame glyphs appear.

Test Plan:
- Reset mid-line (rst pulse, any phase) -> all out fields 0 within the same cycle; no glyph pixels until the following frame start.
- board 10x10 at (100,100), button_size=32, GLYPH 8x16, cell (2,3)=5, glyph row 0 = 8'hFF:
  - out.rgb = 12'h800 for hcount 176..183 on vcount 204, output 3 cycles later.
  - Neighbouring pixels carry the delayed input rgb.
- All cells 0, or all cells 9..15 -> out.rgb equals input rgb delayed by 3 for the whole frame; sync/blank alignment checked on every cycle.
- en=0 latched at frame start, toggled to 1 mid-frame -> no overlay in that frame; overlay appears in the next frame.
- button_num=16, button_size=8 -> cell_x sequence 0..15 per line, never 16; the last cell's glyph is drawn flush (offx = 0).
- Address/data latency: the model memory returns cell_val and glyph_bits one cycle after the address -> glyph pixels land exactly at cell origin + offset; a 1-cycle-late model shows a mismatch (self-check).
